// File: rtl/m_imem_loader_if.sv
// Instruction-memory loader bus: UART receive line in, word-write port and load status out.
interface m_imem_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              w_rxd;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_proc_rst;
    logic              r_done;
    logic              r_err;

    modport master (
        input  w_rxd,
        output r_we, r_addr, r_wdata, r_proc_rst, r_done, r_err
    );

    modport slave (
        output w_rxd,
        input  r_we, r_addr, r_wdata, r_proc_rst, r_done, r_err
    );
endinterface

// File: rtl/m_imem_loader.sv
// Serial program loader: receives a length-prefixed image over UART 8N1 and writes it
// word by word into instruction memory, holding the processor in reset until done.
module m_imem_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned MAX_WORDS    = 4096
) (
    input  logic             w_clk,
    input  logic             w_rst,
    m_imem_loader_if.master  bus
);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {LLenHi, LLenLo, LData, LDone, LErr} ld_state_e;

    logic rx_meta_q, rxs_q, rxs_prev_q;

    rx_state_e       rx_state_q, rx_state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_stb, frm_stb;

    ld_state_e         ld_q, ld_d;
    logic [15:0]       len_q, len_d, new_len;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              proc_rst_q, proc_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= bus.w_rxd;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Strobes are combinational so the loader registers r_we one cycle after the stop sample.
    always_comb begin
        rx_state_d = rx_state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_stb   = 1'b0;
        frm_stb    = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (rxs_prev_q && !rxs_q) begin
                    rx_state_d = RxStart;
                    timer_d    = '0;
                end
            end
            RxStart: begin
                if (timer_q == HALF) begin
                    timer_d    = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rxs_q ? RxIdle : RxData;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RxData: begin
                if (timer_q == FULL) begin
                    timer_d = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) rx_state_d = RxStop;
                    else                   bit_idx_d  = bit_idx_q + 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RxStop: begin
                if (timer_q == FULL) begin
                    timer_d    = '0;
                    byte_stb   = rxs_q;
                    frm_stb    = !rxs_q;
                    rx_state_d = RxIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            rx_state_q <= RxIdle;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    assign new_len = {len_q[15:8], shift_q};

    always_comb begin
        ld_d       = ld_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        last_d     = last_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        proc_rst_d = proc_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        case (ld_q)
            LLenHi: if (byte_stb) begin
                len_d[15:8] = shift_q;
                ld_d        = LLenLo;
            end
            LLenLo: if (byte_stb) begin
                len_d[7:0] = shift_q;
                if (new_len == '0 || 32'(new_len) > MAX_WORDS) begin
                    ld_d  = LErr;
                    err_d = 1'b1;
                end else begin
                    ld_d       = LData;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    last_d     = 1'b0;
                end
            end
            LData: begin
                // Final write went out last cycle; release the processor now.
                if (last_q) begin
                    ld_d       = LDone;
                    done_d     = 1'b1;
                    proc_rst_d = 1'b0;
                end else if (byte_stb) begin
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_idx_q[ADDR_W-1:0];
                        wdata_d    = {word_q, shift_q};
                        word_idx_d = word_idx_q + 1'b1;
                        byte_cnt_d = '0;
                        last_d     = (word_idx_q == len_q - 16'd1);
                    end else begin
                        word_d     = {word_q[15:0], shift_q};
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (frm_stb && ld_q != LDone && ld_q != LErr) begin
            ld_d  = LErr;
            err_d = 1'b1;
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            ld_q       <= LLenHi;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            proc_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_q       <= ld_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            proc_rst_q <= proc_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.r_we       = we_q;
    assign bus.r_addr     = addr_q;
    assign bus.r_wdata    = wdata_q;
    assign bus.r_proc_rst = proc_rst_q;
    assign bus.r_done     = done_q;
    assign bus.r_err      = err_q;
endmodule

// File: tb/tb_m_imem_loader.sv
// Bench for m_imem_loader: header table, directed load/error sequences and randomized
// loads checked against a byte-stream model of the image format.
module tb_m_imem_loader;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    always #5 clk = ~clk;

    m_imem_loader_if #(.ADDR_W(12)) bus ();
    m_imem_loader_if #(.ADDR_W(4))  sbus ();
    assign bus.w_rxd  = rxd;
    assign sbus.w_rxd = rxd;

    m_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(12), .MAX_WORDS(4096)) dut (
        .w_clk (clk),
        .w_rst (rst),
        .bus   (bus)
    );

    // Scaled instance for the full-capacity boundary (keeps the run short).
    m_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .MAX_WORDS(16)) sdut (
        .w_clk (clk),
        .w_rst (rst),
        .bus   (sbus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write monitor
    logic [11:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  s_addr[$];
    logic [31:0] s_data[$];
    int cyc = 0, last_we_cyc = -1, done_cyc = -1;
    logic prev_we = 1'b0, done_prev = 1'b0, proc_at_done = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (bus.r_we) begin
            chk("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
            q_addr.push_back(bus.r_addr);
            q_data.push_back(bus.r_wdata);
            last_we_cyc = cyc;
        end
        if (bus.r_done && !done_prev) begin
            done_cyc     = cyc;
            proc_at_done = bus.r_proc_rst;
        end
        prev_we   = bus.r_we;
        done_prev = bus.r_done;
        if (sbus.r_we) begin
            s_addr.push_back(sbus.r_addr);
            s_data.push_back(sbus.r_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [7:0]  tx[$];
    logic [31:0] exp_words[$];

    task automatic send_all();
        foreach (tx[i]) send_byte(tx[i], 1'b1);
        repeat (40) @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_words.push_back(w);
        tx.push_back(w[31:24]);
        tx.push_back(w[23:16]);
        tx.push_back(w[15:8]);
        tx.push_back(w[7:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q_addr.delete();
        q_data.delete();
        s_addr.delete();
        s_data.delete();
        tx.delete();
        exp_words.delete();
        done_cyc    = -1;
        last_we_cyc = -1;
        repeat (3) @(negedge clk);
    endtask

    task automatic verify_load(input string tag, input int nw, input logic exp_done,
                               input logic exp_err);
        chk({tag, "_nwrites"}, 32'(q_addr.size()), 32'(nw));
        for (int i = 0; i < nw && i < q_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(q_addr[i]), 32'(i));
            chk({tag, "_data"}, q_data[i], exp_words[i]);
        end
        chk({tag, "_done"}, 32'(bus.r_done), 32'(exp_done));
        chk({tag, "_err"}, 32'(bus.r_err), 32'(exp_err));
        chk({tag, "_proc_rst"}, 32'(bus.r_proc_rst), 32'(!exp_done));
        if (exp_done) begin
            chk({tag, "_done_latency"}, 32'(done_cyc), 32'(last_we_cyc + 1));
            chk({tag, "_proc_rst_at_done"}, 32'(proc_at_done), 32'd0);
        end
    endtask

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       exp_err;
    } hdr_vec_t;

    hdr_vec_t hdr_tab[5];

    initial begin
        int n, total, mode, err_at, nw;
        logic [31:0] w;

        hdr_tab[0] = '{8'h00, 8'h00, 1'b1};
        hdr_tab[1] = '{8'h10, 8'h01, 1'b1};
        hdr_tab[2] = '{8'h10, 8'h00, 1'b0};
        hdr_tab[3] = '{8'h00, 8'h01, 1'b0};
        hdr_tab[4] = '{8'hFF, 8'hFF, 1'b1};

        do_reset();
        chk("reset_we", 32'(bus.r_we), 32'd0);
        chk("reset_addr", 32'(bus.r_addr), 32'd0);
        chk("reset_wdata", bus.r_wdata, 32'd0);
        chk("reset_proc_rst", 32'(bus.r_proc_rst), 32'd1);
        chk("reset_done", 32'(bus.r_done), 32'd0);
        chk("reset_err", 32'(bus.r_err), 32'd0);

        // Header table
        for (int i = 0; i < 5; i++) begin
            do_reset();
            send_byte(hdr_tab[i].hi, 1'b1);
            send_byte(hdr_tab[i].lo, 1'b1);
            repeat (20) @(negedge clk);
            chk($sformatf("hdr%0d_err", i), 32'(bus.r_err), 32'(hdr_tab[i].exp_err));
            chk($sformatf("hdr%0d_proc_rst", i), 32'(bus.r_proc_rst), 32'd1);
            chk($sformatf("hdr%0d_done", i), 32'(bus.r_done), 32'd0);
        end

        // Two-word load, then trailing bytes that must be ignored
        do_reset();
        tx.push_back(8'h00);
        tx.push_back(8'h02);
        push_word(32'h2008_1000);
        push_word(32'h0000_0020);
        tx.push_back(8'h11);
        tx.push_back(8'h22);
        tx.push_back(8'h33);
        tx.push_back(8'h44);
        send_all();
        verify_load("two_word", 2, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle, checked before any clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_we", 32'(bus.r_we), 32'd0);
        chk("async_rst_addr", 32'(bus.r_addr), 32'd0);
        chk("async_rst_wdata", bus.r_wdata, 32'd0);
        chk("async_rst_proc_rst", 32'(bus.r_proc_rst), 32'd1);
        chk("async_rst_done", 32'(bus.r_done), 32'd0);
        chk("async_rst_err", 32'(bus.r_err), 32'd0);

        // Framing error in the data phase
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h20, 1'b0);
        repeat (40) @(negedge clk);
        verify_load("framing", 0, 1'b0, 1'b1);

        // Glitch on idle line, then a one-word load
        do_reset();
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        tx.push_back(8'h00);
        tx.push_back(8'h01);
        push_word(32'hDEAD_BEEF);
        send_all();
        verify_load("glitch", 1, 1'b1, 1'b0);

        // Reset mid-word restarts from the header
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        do_reset();
        tx.push_back(8'h00);
        tx.push_back(8'h01);
        push_word(32'hAABB_CCDD);
        send_all();
        verify_load("rst_mid_word", 1, 1'b1, 1'b0);

        // Full-capacity load on the scaled instance
        do_reset();
        tx.push_back(8'h00);
        tx.push_back(8'h10);
        for (int i = 0; i < 16; i++) push_word($urandom);
        send_all();
        chk("full_nwrites", 32'(s_addr.size()), 32'd16);
        if (s_addr.size() == 16) begin
            chk("full_last_addr", 32'(s_addr[15]), 32'hF);
            chk("full_last_data", s_data[15], exp_words[15]);
        end
        chk("full_done", 32'(sbus.r_done), 32'd1);
        chk("full_err", 32'(sbus.r_err), 32'd0);
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        repeat (20) @(negedge clk);
        chk("over_cap_err", 32'(sbus.r_err), 32'd1);
        chk("over_cap_proc_rst", 32'(sbus.r_proc_rst), 32'd1);

        // Randomized loads with optional framing error
        for (int it = 0; it < 6; it++) begin
            do_reset();
            n = $urandom_range(1, 5);
            tx.push_back(8'h00);
            tx.push_back(8'(n));
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                push_word(w);
            end
            total = 2 + 4 * n;
            mode  = $urandom_range(0, 2);
            if (mode == 0)      err_at = $urandom_range(0, total - 1);
            else if (mode == 1) err_at = total;
            else                err_at = -1;
            for (int k = 0; k < total; k++) begin
                if (k == err_at) begin
                    send_byte(tx[k], 1'b0);
                    break;
                end
                send_byte(tx[k], 1'b1);
            end
            if (err_at == total) send_byte(8'h5A, 1'b0);
            repeat (40) @(negedge clk);
            if (err_at >= 0 && err_at < total) begin
                nw = (err_at < 2) ? 0 : (err_at - 2) / 4;
                verify_load($sformatf("rand%0d", it), nw, 1'b0, 1'b1);
            end else begin
                verify_load($sformatf("rand%0d", it), n, 1'b1, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
